uart_rx_param: RTL
==================

// Module: uart_rx_param
// PURPOSE
//  Parametrised UART receiver for the XOR-cipher datapath. Oversamples rx on s_tick, supports 5-9 data bits,
//  runtime none/even/odd parity, 1/1.5/2 stop bits, start-glitch rejection, parity/framing/break flags.
//  Sits between the baud-tick generator and the cipher core / RX FIFO.
// PARAMETERS
//  DBIT        8   data bits per frame, legal 5..9, LSB first
//  OVERSAMPLE  16  s_tick pulses per bit, even, legal 8..32
//  SB_TICK     16  s_tick pulses for stop period (16=1, 24=1.5, 32=2 stop bits at OVERSAMPLE=16)
// PORTS
//  clk          in   1     system clock
//  reset        in   1     asynchronous, active-high
//  rx           in   1     serial line, asynchronous, idle high
//  s_tick       in   1     oversample strobe, one clk wide
//  parity_mode  in   2     00 none, 01 even, 10 odd, 11 reserved = none; sampled in IDLE on start detect
//  rx_done_tick out  1     one-clk pulse, frame complete (also on error)
//  dout         out  DBIT  received word, held until next rx_done_tick
//  parity_err   out  1     parity mismatch of last frame, held with dout
//  frame_err    out  1     stop bit sampled low in last frame, held with dout
//  break_det    out  1     last frame all-zero incl. parity and stop, held with dout
//  busy         out  1     high in any state except IDLE
// BEHAVIOUR
//  Clock/reset: clk; reset asynchronous, active-high. Reset: state IDLE, all counters 0, rx sync flops 1,
//   all outputs 0. Reset mid-frame aborts silently; no rx_done_tick.
//  rx passes a 2-flop synchroniser (reset value 1); all decisions use synced rx_s (+2 clk latency).
//  States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH. Counters: s (tick), n (bit index).
//  IDLE: rx_s==0 -> START, s=0, latch parity_mode. Ticks ignored in IDLE.
//  START: on s_tick, at s==OVERSAMPLE/2-1: sample==0 -> DATA, s=0, n=0; sample==1 -> IDLE (glitch), no flags.
//  DATA: on s_tick, at s==OVERSAMPLE-1: shift sample in at MSB of DBIT register (LSB first), s=0;
//   n==DBIT-1 -> PARITY if parity enabled else STOP; else n++.
//  PARITY: at s==OVERSAMPLE-1 capture parity bit -> STOP. Even: XOR(data,pbit) must be 0; odd: must be 1.
//  STOP: at s==SB_TICK-1 sample stop bit; on same clk load dout, parity_err, frame_err(=~sample),
//   break_det(=frame_err & data==0 & pbit==0 when enabled); assert rx_done_tick.
//   Next state: stop==1 -> IDLE; stop==0 -> WAIT_HIGH.
//  WAIT_HIGH: stay until rx_s==1, then IDLE; prevents repeated frames during a held break.
//  Outputs dout/flags registered, change only on the rx_done_tick cycle; flags never change otherwise.
//  Sample (no macro): rx_s at the decision tick. s_tick with no decision increments s, width $clog2(max(OVERSAMPLE,SB_TICK)).
//  s_tick stuck high: one tick per clk, behaviour identical with compressed time.
// CONFIGURATION
//  UART_RX_MAJORITY_EN defined: sample = majority of rx_s at the last three s_ticks of the window
//   (s = D-2, D-1, D, D = decision count), applied to start, data, parity, stop; single 1-tick glitch rejected.
//  Undefined: single sample at s==D; majority registers absent. Timing of rx_done_tick identical both ways.
// STRUCTURE
//  uart_pkg: parity mode localparams (PAR_NONE/EVEN/ODD), state encoding, OVERSAMPLE/SB_TICK defaults.
//  Sub-module uart_rx_sync: 2-flop synchroniser with configurable reset value; FSMD stays in uart_rx_param.
// TESTING
//  8N1, OVERSAMPLE=16, send 0x55 -> one rx_done_tick, dout=0x55, all flags 0, busy low after.
//  Even parity, send 0xA3 with parity bit 1 (wrong) -> dout=0xA3, parity_err=1, frame_err=0.
//  Odd parity, 0xA3 with pbit 1 -> parity_err=0; DBIT=5, 0x1F -> dout=5'h1F.
//  Stop bit low, data 0x3C -> frame_err=1, dout=0x3C; rx held high next frame -> frame_err clears.
//  rx low 40 bit-times -> exactly one rx_done_tick, break_det=1, frame_err=1, none until rx high + new start.
//  rx low 6 ticks then high -> no rx_done_tick, back to IDLE; reset mid-DATA -> outputs 0, no pulse.
//  With UART_RX_MAJORITY_EN: 1-tick high glitch at mid of 0-bit of 0x00 -> dout=0x00.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: parity mode codes,
// FSM state encoding, default oversample/stop timing.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int SB_TICK_DEF    = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } state_t;

  // Reserved code 2'b11 behaves as no parity.
  function automatic logic par_on(input logic [1:0] m);
    return (m == PAR_EVEN) || (m == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input.
// Ports: clk, reset (async, active-high), d (async in), q (synced).
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with runtime parity,
// glitch rejection and parity/framing/break flags.
// Ports: clk, reset (async, active-high), rx, s_tick, parity_mode[1:0]
//  -> rx_done_tick, dout[DBIT-1:0], parity_err, frame_err, break_det, busy.
// Option: UART_RX_MAJORITY_EN selects 3-tick majority sampling.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int SB_TICK    = SB_TICK_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  input  logic [1:0]      parity_mode,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            parity_err,
  output logic            frame_err,
  output logic            break_det,
  output logic            busy
);

  localparam int SMAX =
    (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int SW = $clog2(SMAX);
  localparam int NW = $clog2(DBIT);

  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  logic rx_s;
  logic sample;

  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // Last two tick samples; with the current one they span
  // s = D-2..D of whichever window is deciding.
  logic [1:0] hist;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist <= 2'b11;
    end else if (s_tick) begin
      hist <= {hist[0], rx_s};
    end
  end

  assign sample = (hist[1] & hist[0]) |
                  (hist[1] & rx_s) |
                  (hist[0] & rx_s);
`else
  assign sample = rx_s;
`endif

  state_t            state_q, state_d;
  logic [SW-1:0]     s_q, s_d;
  logic [NW-1:0]     n_q, n_d;
  logic [DBIT-1:0]   b_q, b_d;
  logic              pbit_q, pbit_d;
  logic [1:0]        pmode_q, pmode_d;
  logic [DBIT-1:0]   dout_q, dout_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              brk_q, brk_d;
  logic              done_q, done_d;
  logic              par_bad;
  logic              par_mix;

  assign par_mix = (^b_q) ^ pbit_q;

  always_comb begin
    par_bad = 1'b0;
    unique case (1'b1)
      pmode_q == PAR_EVEN: par_bad = par_mix;
      pmode_q == PAR_ODD:  par_bad = ~par_mix;
      default:             par_bad = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      pbit_q  <= 1'b0;
      pmode_q <= PAR_NONE;
      dout_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      pbit_q  <= pbit_d;
      pmode_q <= pmode_d;
      dout_q  <= dout_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      brk_q   <= brk_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    pbit_d  = pbit_q;
    pmode_d = pmode_q;
    dout_d  = dout_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    brk_d   = brk_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          s_d     = '0;
          pmode_d = parity_mode;
          pbit_d  = 1'b0;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_q == S_MID) begin
            if (sample) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DATA;
              s_d     = '0;
              n_d     = '0;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT) begin
            s_d = '0;
            b_d = {sample, b_q[DBIT-1:1]};
            if (n_q == N_LAST) begin
              state_d = par_on(pmode_q) ? ST_PARITY : ST_STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (s_tick) begin
          if (s_q == S_BIT) begin
            s_d     = '0;
            pbit_d  = sample;
            state_d = ST_STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP) begin
            s_d    = '0;
            done_d = 1'b1;
            dout_d = b_q;
            perr_d = par_bad;
            ferr_d = ~sample;
            // pbit_q is cleared at start, so it only
            // vetoes a break when parity was received.
            brk_d  = ~sample & (b_q == '0) & ~pbit_q;
            state_d = sample ? ST_IDLE : ST_WAIT_HIGH;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rx_done_tick = done_q;
  assign dout         = dout_q;
  assign parity_err   = perr_q;
  assign frame_err    = ferr_q;
  assign break_det    = brk_q;
  assign busy         = (state_q != ST_IDLE);

endmodule
